alu_exec: RTL and testbench

Execute/write-back sequencer for the CPU datapath. It accepts one decoded instruction at a time over a valid/ready handshake and drives the register file's read addresses. It consumes the two operand values the register file returns one clock later, computes the result (single-cycle logic ops, multi-cycle shifts and, optionally, multiply) and writes it back through the register file's masked write port. It is the only agent driving the register file's address, mask and write-data inputs.

---
 rtl/alu_exec.sv | 182 ++++++++++++++++++
 tb/tb_alu_exec.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec: serial execute/write-back sequencer driving a register file's read, mask and write ports.
// Latency: accept->WB in 3 cycles for logic ops, 2+max(1,k) for shift by k, N+2 for MUL (ALU_MUL_EN).
// Backpressure: in_ready only in IDLE; an offer while busy is ignored and must be held until accepted.
module alu_exec #(
  parameter int N = 32,
  parameter int M = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     op,
  input  logic [M-1:0]   rd,
  input  logic [M-1:0]   rs1,
  input  logic [M-1:0]   rs2,
  input  logic [N/8-1:0] lanes,
  output logic [M-1:0]   r1,
  output logic [M-1:0]   r2,
  input  logic [N-1:0]   v1,
  input  logic [N-1:0]   v2,
  output logic [M-1:0]   w1,
  output logic [N-1:0]   mask,
  output logic [N-1:0]   w,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  state_t state, state_nx;

  logic [3:0]     op_q;
  logic [M-1:0]   rd_q;
  logic [N/8-1:0] lanes_q;
  logic           first;
  logic [N-1:0]   acc, acc_nx;
  logic [SW-1:0]  cnt, cnt_nx;
  logic [SW-1:0]  amt;
  logic [N-1:0]   src, sh, res;
  logic           legal, fin;
`ifdef ALU_MUL_EN
  logic [N-1:0]   mcand, mcand_nx, mplier, mplier_nx;
`endif

  assign amt = v2[SW-1:0];
  // Shift operand is the fresh register value on the first EXEC cycle, the running accumulator afterwards.
  assign src = first ? v1 : acc;
  assign sh  = op_q[0] ? (src >> 1) : (src << 1);

  // Opcode decode, per-cycle result and the EXEC completion condition.
  always_comb begin
    legal  = 1'b0;
    fin    = 1'b0;
    res    = '0;
    acc_nx = acc;
    cnt_nx = cnt;
`ifdef ALU_MUL_EN
    mcand_nx  = mcand;
    mplier_nx = mplier;
`endif
    case (op_q)
      4'd0: begin legal = 1'b1; fin = 1'b1; res = v1 + v2; end
      4'd1: begin legal = 1'b1; fin = 1'b1; res = v1 - v2; end
      4'd2: begin legal = 1'b1; fin = 1'b1; res = v1 & v2; end
      4'd3: begin legal = 1'b1; fin = 1'b1; res = v1 | v2; end
      4'd4: begin legal = 1'b1; fin = 1'b1; res = v1 ^ v2; end
      4'd5: begin legal = 1'b1; fin = 1'b1; res = v1; end
      4'd6, 4'd7: begin
        legal = 1'b1;
        if (first) begin
          // Amount 0 and 1 both retire in the single first cycle.
          if (amt <= SW'(1)) begin
            fin = 1'b1;
            res = (amt == '0) ? v1 : sh;
          end else begin
            acc_nx = sh;
            cnt_nx = amt - SW'(1);
          end
        end else begin
          acc_nx = sh;
          cnt_nx = cnt - SW'(1);
          fin    = (cnt == SW'(1));
          res    = sh;
        end
      end
`ifdef ALU_MUL_EN
      4'd8: begin
        legal = 1'b1;
        if (first) begin
          acc_nx    = v2[0] ? v1 : '0;
          mcand_nx  = v1 << 1;
          mplier_nx = v2 >> 1;
          cnt_nx    = SW'(N - 1);
        end else begin
          acc_nx    = acc + (mplier[0] ? mcand : '0);
          mcand_nx  = mcand << 1;
          mplier_nx = mplier >> 1;
          cnt_nx    = cnt - SW'(1);
          fin       = (cnt == SW'(1));
        end
        res = acc_nx;
      end
`endif
      default: begin legal = 1'b0; fin = 1'b1; end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: strictly one instruction in flight.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nx = READ;
      READ:    state_nx = EXEC;
      EXEC:    if (fin) state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Instruction latch, read addresses, iterative operands and write-back registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= '0;
      rd_q    <= '0;
      lanes_q <= '0;
      r1      <= '0;
      r2      <= '0;
      w1      <= '0;
      w       <= '0;
      first   <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
`ifdef ALU_MUL_EN
      mcand   <= '0;
      mplier  <= '0;
`endif
    end else begin
      if (state == IDLE && in_valid) begin
        op_q    <= op;
        rd_q    <= rd;
        lanes_q <= lanes;
        r1      <= rs1;
        r2      <= rs2;
      end
      first <= (state == READ);
      if (state == EXEC) begin
        acc <= acc_nx;
        cnt <= cnt_nx;
`ifdef ALU_MUL_EN
        mcand  <= mcand_nx;
        mplier <= mplier_nx;
`endif
        if (fin) begin
          w  <= res;
          w1 <= rd_q;
        end
      end
    end
  end

  // Byte-lane mask, driven only in WB for a legal op and never while reset is asserted.
  always_comb begin
    mask = '0;
    if (state == WB && legal && rst_n) begin
      for (int i = 0; i < N/8; i++) mask[8*i +: 8] = {8{lanes_q[i]}};
    end
  end

  assign in_ready = (state == IDLE) && rst_n;
  assign busy     = (state != IDLE);
  assign done     = (state == WB);
  assign err      = (state == WB) && !legal;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed checks of alu_exec against a behavioural register file with hand-computed results.
// Latency: cycles are counted from the accept edge (edge 0); outputs sampled on the falling edge.
// Backpressure: each instruction waits (bounded) for in_ready before being offered.
module tb_alu_exec;
  localparam int N = 32;
  localparam int M = 2;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, busy, done, err;
  logic [3:0]    op;
  logic [M-1:0]  rd, rs1, rs2, r1, r2, w1;
  logic [N/8-1:0] lanes;
  logic [N-1:0]  v1, v2, mask, w;

  logic [N-1:0]  regs [4];
  logic          pl_en;
  logic [1:0]    pl_idx;
  logic [N-1:0]  pl_dat;

  int n_cmp = 0;
  int n_bad = 0;
  int stray = 0;

  int            wb_cyc;
  logic [N-1:0]  wb_w, wb_mask;
  logic          wb_err, c1_busy;
  logic [M-1:0]  c1_r1, c1_r2;

  always #5 clk = ~clk;

  alu_exec #(.N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .lanes(lanes),
    .r1(r1), .r2(r2), .v1(v1), .v2(v2), .w1(w1), .mask(mask), .w(w),
    .busy(busy), .done(done), .err(err)
  );

  // Register file: registered reads, bit-masked write every clock, plus a bench preload port.
  always @(posedge clk) begin
    v1 <= regs[r1];
    v2 <= regs[r2];
    if (pl_en) regs[pl_idx] <= pl_dat;
    else for (int b = 0; b < N; b++) if (mask[b]) regs[w1][b] <= w[b];
  end

  // Any nonzero mask outside the WB cycle is recorded.
  always @(negedge clk) if (mask != '0 && !done) stray++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [1:0] idx, input logic [N-1:0] dat);
    pl_en = 1'b1; pl_idx = idx; pl_dat = dat;
    @(posedge clk);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic accept(input logic [3:0] o, input logic [1:0] d, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [3:0] ln);
    int t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    check("accept_ready", 32'(in_ready), 32'd1);
    op = o; rd = d; rs1 = s1; rs2 = s2; lanes = ln; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    c1_r1 = r1; c1_r2 = r2; c1_busy = busy;
  endtask

  task automatic wait_wb();
    int cyc = 1;
    while (!done && cyc < 200) begin @(negedge clk); cyc++; end
    wb_cyc  = done ? cyc : -1;
    wb_w    = w;
    wb_mask = mask;
    wb_err  = err;
  endtask

  task automatic run(input logic [3:0] o, input logic [1:0] d, input logic [1:0] s1,
                     input logic [1:0] s2, input logic [3:0] ln);
    accept(o, d, s1, s2, ln);
    wait_wb();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0; lanes = '0;
    pl_en = 1'b0; pl_idx = '0; pl_dat = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_ctl", 32'({busy, done, err}), 32'd0);
    check("rst_addr", 32'({r1, r2, w1}), 32'd0);
    check("rst_mask", mask, 32'd0);
    check("rst_w", w, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // ADD 5+7 into r3
    preload(2'd0, 32'd0); preload(2'd1, 32'd5); preload(2'd2, 32'd7); preload(2'd3, 32'd0);
    run(4'd0, 2'd3, 2'd1, 2'd2, 4'hF);
    check("add_r1", 32'(c1_r1), 32'd1);
    check("add_r2", 32'(c1_r2), 32'd2);
    check("add_busy_c1", 32'(c1_busy), 32'd1);
    check("add_wb_cyc", 32'(wb_cyc), 32'd3);
    check("add_w", wb_w, 32'd12);
    check("add_mask", wb_mask, 32'hFFFFFFFF);
    check("add_err", 32'(wb_err), 32'd0);
    @(negedge clk);
    check("add_ready_c4", 32'(in_ready), 32'd1);
    check("add_reg3", regs[3], 32'd12);

    // SUB 0-1 with low two lanes
    preload(2'd0, 32'd0); preload(2'd1, 32'd1); preload(2'd2, 32'hDEADBEEF);
    run(4'd1, 2'd2, 2'd0, 2'd1, 4'b0011);
    check("sub_wb_cyc", 32'(wb_cyc), 32'd3);
    check("sub_w", wb_w, 32'hFFFFFFFF);
    check("sub_mask", wb_mask, 32'h0000FFFF);
    @(negedge clk);
    check("sub_reg2", regs[2], 32'hDEADFFFF);

    // SHL 1 by 31
    preload(2'd3, 32'd31);
    run(4'd6, 2'd0, 2'd1, 2'd3, 4'hF);
    check("shl31_wb_cyc", 32'(wb_cyc), 32'd33);
    check("shl31_w", wb_w, 32'h80000000);
    @(negedge clk);
    check("shl31_reg0", regs[0], 32'h80000000);

    // SHR by 0 and by 4
    preload(2'd3, 32'd0);
    run(4'd7, 2'd1, 2'd2, 2'd3, 4'hF);
    check("shr0_wb_cyc", 32'(wb_cyc), 32'd3);
    check("shr0_w", wb_w, 32'hDEADFFFF);
    preload(2'd3, 32'd4);
    run(4'd7, 2'd1, 2'd2, 2'd3, 4'hF);
    check("shr4_wb_cyc", 32'(wb_cyc), 32'd6);
    check("shr4_w", wb_w, 32'h0DEADFFF);

    // Bitwise ops and MOV
    preload(2'd0, 32'hFF00FF00); preload(2'd1, 32'h0FF00FF0);
    run(4'd2, 2'd3, 2'd0, 2'd1, 4'hF); check("and_w", wb_w, 32'h0F000F00);
    run(4'd3, 2'd3, 2'd0, 2'd1, 4'hF); check("or_w",  wb_w, 32'hFFF0FFF0);
    run(4'd4, 2'd3, 2'd0, 2'd1, 4'hF); check("xor_w", wb_w, 32'hF0F0F0F0);
    run(4'd5, 2'd3, 2'd0, 2'd1, 4'hF); check("mov_w", wb_w, 32'hFF00FF00);
    @(negedge clk);
    check("mov_reg3", regs[3], 32'hFF00FF00);

    // Illegal opcode: err with done, no write
    run(4'hF, 2'd3, 2'd0, 2'd1, 4'hF);
    check("ill_wb_cyc", 32'(wb_cyc), 32'd3);
    check("ill_err", 32'(wb_err), 32'd1);
    check("ill_mask", wb_mask, 32'd0);
    @(negedge clk);
    check("ill_reg3", regs[3], 32'hFF00FF00);

    // Legal op with no lanes
    run(4'd0, 2'd3, 2'd0, 2'd1, 4'h0);
    check("nolane_wb_cyc", 32'(wb_cyc), 32'd3);
    check("nolane_err", 32'(wb_err), 32'd0);
    check("nolane_mask", wb_mask, 32'd0);
    @(negedge clk);
    check("nolane_reg3", regs[3], 32'hFF00FF00);

    // MUL 0x10000 * 0x10001
    preload(2'd0, 32'h00010000); preload(2'd1, 32'h00010001);
    run(4'd8, 2'd3, 2'd0, 2'd1, 4'hF);
`ifdef ALU_MUL_EN
    check("mul_wb_cyc", 32'(wb_cyc), 32'd34);
    check("mul_w", wb_w, 32'h00010000);
    check("mul_err", 32'(wb_err), 32'd0);
    @(negedge clk);
    check("mul_reg3", regs[3], 32'h00010000);
`else
    check("mul_wb_cyc", 32'(wb_cyc), 32'd3);
    check("mul_err", 32'(wb_err), 32'd1);
    check("mul_mask", wb_mask, 32'd0);
    @(negedge clk);
    check("mul_reg3", regs[3], 32'hFF00FF00);
`endif

    // Reset in the middle of a long shift
    preload(2'd1, 32'd1); preload(2'd3, 32'd31); preload(2'd2, 32'h12345678);
    accept(4'd6, 2'd2, 2'd1, 2'd3, 4'hF);
    repeat (8) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_mask", mask, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", 32'(in_ready), 32'd1);
    check("midrst_reg2", regs[2], 32'h12345678);
    preload(2'd0, 32'd5); preload(2'd1, 32'd7);
    run(4'd0, 2'd3, 2'd0, 2'd1, 4'hF);
    check("post_add_wb_cyc", 32'(wb_cyc), 32'd3);
    check("post_add_w", wb_w, 32'd12);
    @(negedge clk);
    check("post_add_reg3", regs[3], 32'd12);

    check("stray_mask", 32'(stray), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
